// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle between AHB managers and the round-robin arbiter.
// The manager side drives requests and the muxed transfer controls; the arbiter side returns grant and ownership.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] i_HBUSREQ;
  logic [NUM_MASTERS-1:0] i_HLOCK;
  logic [1:0]             i_HTRANS;
  logic [2:0]             i_HBURST;
  logic                   i_HREADY;
  logic [NUM_MASTERS-1:0] o_HGRANT;
  logic [3:0]             o_HMASTER;
  logic [3:0]             o_HMASTER_DATA;
  logic                   o_HMASTLOCK;

  modport master (
    output i_HBUSREQ, i_HLOCK, i_HTRANS, i_HBURST, i_HREADY,
    input  o_HGRANT, o_HMASTER, o_HMASTER_DATA, o_HMASTLOCK
  );

  modport slave (
    input  i_HBUSREQ, i_HLOCK, i_HTRANS, i_HBURST, i_HREADY,
    output o_HGRANT, o_HMASTER, o_HMASTER_DATA, o_HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with fixed-length burst and locked-sequence hold.
// Drives one-hot grant plus the address/data-phase owner indices for the bus muxes.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic          i_HCLK,
  input  logic          i_HRESETn,
  ahb_arbiter_if.slave  bus
);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [3:0]             ptr_reg, ptr_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic [3:0]             hmaster_reg;
  logic [3:0]             hmaster_data_reg;
  logic                   hmastlock_reg;

  logic [15:0] req_ext;
  logic [15:0] lock_ext;
  logic [3:0]  grant_idx;
  logic        locked;
  logic        burst_hold;
  logic        win_found;
  logic [3:0]  win_idx;

  assign req_ext  = 16'(bus.i_HBUSREQ);
  assign lock_ext = 16'(bus.i_HLOCK);

  always_comb begin
    grant_idx = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_reg[i]) grant_idx = 4'(i);
    end
  end

  assign locked = lock_ext[grant_idx];

  // Beat counter only tracks fixed-length bursts; INCR/SINGLE leave it at zero.
  always_comb begin
    cnt_next   = cnt_reg;
    burst_hold = 1'b0;
    case (bus.i_HTRANS)
      2'b10: begin
        case (bus.i_HBURST)
          3'b010, 3'b011: begin cnt_next = 4'd3;  burst_hold = 1'b1; end
          3'b100, 3'b101: begin cnt_next = 4'd7;  burst_hold = 1'b1; end
          3'b110, 3'b111: begin cnt_next = 4'd15; burst_hold = 1'b1; end
          default:        cnt_next = 4'd0;
        endcase
      end
      2'b11: begin
        if (cnt_reg != 4'd0) begin
          cnt_next   = cnt_reg - 4'd1;
          burst_hold = (cnt_reg != 4'd1);
        end
      end
      2'b01:   burst_hold = (cnt_reg != 4'd0);
      default: cnt_next = 4'd0;
    endcase
  end

  // Scan starts just after the last winner so the current owner ranks last.
  always_comb begin
    logic [4:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand      = 5'd0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, ptr_reg} + 5'(k);
      if (cand >= 5'(NUM_MASTERS)) cand = cand - 5'(NUM_MASTERS);
      if (!win_found && req_ext[cand[3:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    if (!burst_hold && !locked) begin
      if (win_found) begin
        grant_next = NUM_MASTERS'(1) << win_idx;
        ptr_next   = win_idx;
      end else begin
        grant_next = DEF_GRANT;
      end
    end
  end

  always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
    if (!i_HRESETn) begin
      grant_reg        <= DEF_GRANT;
      ptr_reg          <= DEF_IDX;
      cnt_reg          <= 4'd0;
      hmaster_reg      <= DEF_IDX;
      hmaster_data_reg <= DEF_IDX;
      hmastlock_reg    <= 1'b0;
    end else if (bus.i_HREADY) begin
      grant_reg        <= grant_next;
      ptr_reg          <= ptr_next;
      cnt_reg          <= cnt_next;
      hmaster_reg      <= grant_idx;
      hmaster_data_reg <= hmaster_reg;
      hmastlock_reg    <= locked;
    end
  end

  assign bus.o_HGRANT       = grant_reg;
  assign bus.o_HMASTER      = hmaster_reg;
  assign bus.o_HMASTER_DATA = hmaster_data_reg;
  assign bus.o_HMASTLOCK    = hmastlock_reg;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed-vector bench for ahb_arbiter: round-robin, burst hold, wait states,
// lock hold, early termination and reset in the middle of a burst.
module tb_ahb_arbiter;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011,
                         INCR8 = 3'b101, INCR16 = 3'b111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS(4),
    .DEFAULT_MASTER(0)
  ) dut (
    .i_HCLK    (clk),
    .i_HRESETn (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    bus.i_HBUSREQ = req;
    bus.i_HLOCK   = lock;
    bus.i_HTRANS  = trans;
    bus.i_HBURST  = burst;
    bus.i_HREADY  = ready;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] hm,
                           input logic [3:0] hd, input logic lk);
    check({tag, ".grant"}, 32'(bus.o_HGRANT), 32'(g));
    check({tag, ".hmaster"}, 32'(bus.o_HMASTER), 32'(hm));
    check({tag, ".hmaster_data"}, 32'(bus.o_HMASTER_DATA), 32'(hd));
    check({tag, ".hmastlock"}, 32'(bus.o_HMASTLOCK), 32'(lk));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
      step();
    end
    check_all("reset", 4'b0001, 4'd0, 4'd0, 1'b0);
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    #2 rst_n = 1'b1;
    step();
    check_all("release", 4'b0001, 4'd0, 4'd0, 1'b0);

    // Round-robin with all requesting
    drive(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
    step(); check_all("rr1", 4'b0010, 4'd0, 4'd0, 1'b0);
    step(); check_all("rr2", 4'b0100, 4'd1, 4'd0, 1'b0);
    step(); check_all("rr3", 4'b1000, 4'd2, 4'd1, 1'b0);
    step(); check_all("rr4", 4'b0001, 4'd3, 4'd2, 1'b0);

    // Hand the bus to manager 1, then INCR4 while manager 2 requests
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    step(); check("incr4.pre", 32'(bus.o_HGRANT), 32'(4'b0010));
    drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
    step(); check("incr4.nonseq", 32'(bus.o_HGRANT), 32'(4'b0010));
    drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
    step(); check("incr4.seq1", 32'(bus.o_HGRANT), 32'(4'b0010));
    step(); check("incr4.seq2", 32'(bus.o_HGRANT), 32'(4'b0010));
    check("incr4.hmaster", 32'(bus.o_HMASTER), 32'(4'd1));
    step(); check("incr4.seq3", 32'(bus.o_HGRANT), 32'(4'b0100));

    // Manager 2 INCR4 with two wait states on beat 2
    drive(4'b1100, 4'b0000, NONSEQ, INCR4, 1'b1);
    step(); check_all("ws.nonseq", 4'b0100, 4'd2, 4'd1, 1'b0);
    drive(4'b1100, 4'b0000, SEQ, INCR4, 1'b1);
    step(); check_all("ws.seq1", 4'b0100, 4'd2, 4'd2, 1'b0);
    bus.i_HREADY = 1'b0;
    step(); check_all("ws.wait1", 4'b0100, 4'd2, 4'd2, 1'b0);
    step(); check_all("ws.wait2", 4'b0100, 4'd2, 4'd2, 1'b0);
    bus.i_HREADY = 1'b1;
    step(); check("ws.seq2", 32'(bus.o_HGRANT), 32'(4'b0100));
    step(); check("ws.seq3", 32'(bus.o_HGRANT), 32'(4'b1000));

    // Locked INCR sequence from manager 3 while everyone requests
    drive(4'b1111, 4'b1000, NONSEQ, INCR, 1'b1);
    step(); check_all("lock.nonseq", 4'b1000, 4'd3, 4'd2, 1'b1);
    drive(4'b1111, 4'b1000, SEQ, INCR, 1'b1);
    step(); check_all("lock.seq1", 4'b1000, 4'd3, 4'd3, 1'b1);
    drive(4'b1111, 4'b1000, BUSY, INCR, 1'b1);
    step(); check_all("lock.busy", 4'b1000, 4'd3, 4'd3, 1'b1);
    drive(4'b1111, 4'b0000, SEQ, INCR, 1'b1);
    step(); check_all("lock.release", 4'b0001, 4'd3, 4'd3, 1'b0);

    // INCR8 from manager 0, IDLE after beat 2 terminates early
    drive(4'b0011, 4'b0000, NONSEQ, INCR8, 1'b1);
    step(); check("incr8.nonseq", 32'(bus.o_HGRANT), 32'(4'b0001));
    drive(4'b0011, 4'b0000, SEQ, INCR8, 1'b1);
    step(); check("incr8.seq1", 32'(bus.o_HGRANT), 32'(4'b0001));
    drive(4'b0011, 4'b0000, IDLE, INCR8, 1'b1);
    step(); check("incr8.idle", 32'(bus.o_HGRANT), 32'(4'b0010));

    // INCR16 from manager 1, reset pulsed mid-burst
    drive(4'b0110, 4'b0000, NONSEQ, INCR16, 1'b1);
    step(); check("incr16.nonseq", 32'(bus.o_HGRANT), 32'(4'b0010));
    drive(4'b0110, 4'b0000, SEQ, INCR16, 1'b1);
    step(); check("incr16.seq1", 32'(bus.o_HGRANT), 32'(4'b0010));
    #1 rst_n = 1'b0;
    #1 check_all("midrst", 4'b0001, 4'd0, 4'd0, 1'b0);
    #1 rst_n = 1'b1;
    // Burst count discarded: SEQ with cnt 0 re-arbitrates from ptr 0
    step(); check("postrst.seq1", 32'(bus.o_HGRANT), 32'(4'b0010));
    step(); check("postrst.seq2", 32'(bus.o_HGRANT), 32'(4'b0100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that sits directly upstream of each AHB manager. It consumes every manager's bus request and lock signals and returns a one-hot grant. It tracks fixed-length bursts and locked sequences so ownership never changes mid-transfer. It also drives the HMASTER/HMASTLOCK signals used by the address and write-data multiplexers.

## Interface
- NUM_MASTERS, 4: number of managers; legal range 2..16.
- DEFAULT_MASTER, 0: index granted when nobody requests; also the reset owner.
- i_HCLK  in  1  bus clock; all state on rising edge.
- i_HRESETn  in  1  asynchronous, active-low reset.
- i_HBUSREQ  in  NUM_MASTERS  per-manager bus request.
- i_HLOCK  in  NUM_MASTERS  per-manager locked-transfer request.
- i_HTRANS  in  2  muxed HTRANS of the current address-phase owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- i_HBURST  in  3  muxed HBURST of the current address-phase owner.
- i_HREADY  in  1  bus-wide ready.
- o_HGRANT  out  NUM_MASTERS  one-hot grant.
- o_HMASTER  out  4  index of the address-phase owner.
- o_HMASTER_DATA  out  4  index of the data-phase owner; steers the HWDATA mux.
- o_HMASTLOCK  out  1  current address phase is locked.

## Operation
- **Reset values** (asynchronous, while i_HRESETn=0):
  - o_HGRANT = one-hot(DEFAULT_MASTER).
  - o_HMASTER = o_HMASTER_DATA = DEFAULT_MASTER.
  - o_HMASTLOCK = 0.
  - Beat counter cnt = 0; round-robin pointer ptr = DEFAULT_MASTER.
- **Freeze rule:** every register updates only on an edge with i_HREADY=1. With i_HREADY=0, all outputs and internal state hold.
- **Lock:** locked = i_HLOCK[index of o_HGRANT].
- **Burst counter** (evaluated on HREADY edges):
  - NONSEQ with HBURST=010/011: cnt <= 3. With 100/101: cnt <= 7. With 110/111: cnt <= 15. Grant is held on this edge.
  - SEQ with cnt>0: cnt <= cnt-1. Grant may change on this edge only if cnt==1, i.e. the last beat is being issued.
  - BUSY: cnt unchanged. Grant held if cnt>0.
  - IDLE, or NONSEQ with SINGLE/INCR (000/001), while cnt>0 is an early termination: cnt <= 0 and re-arbitration is allowed.
  - SINGLE and INCR never load cnt. Re-arbitration is allowed on every beat of them.
- **Re-arbitration** happens on an HREADY edge when not held and not locked:
  - Scan indices ptr+1 … ptr+NUM_MASTERS modulo NUM_MASTERS. Grant the first with i_HBUSREQ=1; the current owner is therefore lowest priority.
  - If there are no requests, grant DEFAULT_MASTER.
  - ptr <= new grantee when a request won. ptr is unchanged on a default grant.
- **Locked hold:** grant is held on every edge while locked=1, regardless of other requests or burst state.
- **Pipeline** (each stage on an HREADY edge):
  - o_HMASTER <= index(o_HGRANT).
  - o_HMASTLOCK <= locked.
  - o_HMASTER_DATA <= o_HMASTER.
- **Unsupported:** SPLIT/RETRY. HRESP is not an input.

## Timing
- **Request to grant:** request sampled at edge N (HREADY=1, not held) gives o_HGRANT at N+1.
- **Grant to ownership:** o_HMASTER follows at the next HREADY edge; o_HMASTER_DATA one HREADY edge after that.
- **Stall stretching:** wait states (HREADY=0) stretch every stage by exactly the number of low cycles.
- **Fixed-burst hold:** a 4-beat burst holds grant through the NONSEQ edge and 2 SEQ edges. The new grant appears on the edge issuing the 4th beat (SEQ with cnt==1).
- **Simultaneous events:** if lock deasserts on the same edge the burst ends, re-arbitration occurs on that edge.
- **Reset mid-burst:** immediate return to reset values. cnt is discarded.

## Test plan
- **Reset:** hold i_HRESETn=0 with random inputs. Expect o_HGRANT=0001, o_HMASTER=0, o_HMASTER_DATA=0, o_HMASTLOCK=0. Release: outputs unchanged with no requests.
- **Round-robin:** i_HBUSREQ=1111, HTRANS=NONSEQ SINGLE, HREADY=1. Expect grants cycling 0010, 0100, 1000, 0001 on successive edges. o_HMASTER lags by 1 cycle and o_HMASTER_DATA by 2.
- **INCR4 hold:** manager 1 issues NONSEQ INCR4 then 3×SEQ while manager 2 requests. o_HGRANT stays 0010 until the 3rd SEQ edge, then becomes 0100.
- **Wait states mid-burst:** 2 cycles of HREADY=0 inserted on beat 2. Grant, cnt and o_HMASTER frozen for those 2 cycles; handover is delayed by exactly 2 cycles.
- **Lock:** manager 3 asserts i_HLOCK with INCR transfers while all others request. Grant stays 1000 and o_HMASTLOCK=1 until i_HLOCK[3]=0. Next grant is 0001.
- **Early termination and mid-burst reset:**
  - IDLE after beat 2 of INCR8: re-arbitration on that edge.
  - i_HRESETn pulsed low during an INCR16: outputs return to reset values immediately, cnt=0.
